// File: rtl/div32_seq_pkg.sv
// Shared definitions for the sequential divider.
//   DataWidth   : default operand/result width
//   div_state_e : controller states (idle, iterate, sign fix-up)
package div32_seq_pkg;

  localparam int unsigned DataWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div32_seq_step.sv
// One combinational restoring-division step.
// Ports:
//   rem      : partial remainder before the step (Width+1 bits)
//   quo      : quotient/dividend shift register before the step
//   divisor  : divisor magnitude
//   rem_next : partial remainder after the step
//   quo_next : shift register after the step, new quotient bit in bit 0
module div32_seq_step
  import div32_seq_pkg::*;
#(
  parameter int unsigned Width = DataWidth
) (
  input  logic [Width:0]   rem,
  input  logic [Width-1:0] quo,
  input  logic [Width-1:0] divisor,
  output logic [Width:0]   rem_next,
  output logic [Width-1:0] quo_next
);

  logic [Width:0]   shifted;
  logic [Width+1:0] sum;
  logic             borrow;
  logic             unused_rem_msb;

  always_comb begin
    // Shift the next dividend bit in from the top of the quotient register.
    shifted  = {rem[Width-1:0], quo[Width-1]};
    // Subtract as add-with-complement; carry out set means shifted >= divisor.
    sum      = {1'b0, shifted} + {1'b0, ~{1'b0, divisor}} + (Width + 2)'(1);
    borrow   = ~sum[Width+1];
    rem_next = borrow ? shifted : sum[Width:0];
    quo_next = {quo[Width-2:0], ~borrow};
  end

  // After any step the remainder is below 2^Width, so its top bit is always zero.
  assign unused_rem_msb = rem[Width];

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring integer divider, one quotient bit per clock.
// lo = quotient, hi = remainder. Fixed latency of Width+2 cycles.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : request, accepted only when idle and not in the done cycle
//   signed_mode : 1 = two's-complement divide, 0 = unsigned (sampled with start)
//   a, b        : dividend, divisor (sampled with start)
//   busy        : high from the accepting edge until done
//   done        : one-cycle completion pulse
//   hi, lo      : remainder, quotient; held until the next done
//   div_by_zero : divisor was zero for the completed operation
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int unsigned Width = DataWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] hi,
  output logic [Width-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CntWidth = $clog2(Width) + 1;

  div_state_e          state_q, state_d;
  logic [CntWidth-1:0] count_q, count_d;
  logic [Width:0]      rem_q, rem_d;
  logic [Width-1:0]    quo_q, quo_d;
  logic [Width-1:0]    dvs_q, dvs_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic                zero_q, zero_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;
  logic [Width-1:0]    hi_q, hi_d;
  logic [Width-1:0]    lo_q, lo_d;

  logic [Width:0]      step_rem;
  logic [Width-1:0]    step_quo;
  logic                a_neg, b_neg;

  function automatic logic [Width-1:0] negate(input logic [Width-1:0] x);
    return ~x + Width'(1);
  endfunction

  div32_seq_step #(
    .Width(Width)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  assign a_neg = signed_mode & a[Width-1];
  assign b_neg = signed_mode & b[Width-1];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        // The done cycle is spent in idle; a request there is deliberately dropped.
        if (start && !done_q) begin
          state_d = StRun;
          count_d = '0;
          rem_d   = '0;
          quo_d   = a_neg ? negate(a) : a;
          dvs_d   = b_neg ? negate(b) : b;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          zero_d  = (b == '0);
          busy_d  = 1'b1;
        end
      end

      StRun: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + CntWidth'(1);
        if (count_q == CntWidth'(Width - 1)) begin
          state_d = StFix;
        end
      end

      StFix: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = zero_q;
        // A zero divisor accepts every trial, leaving an all-ones quotient and
        // |a| in the remainder; the remainder sign fix then restores a exactly.
        lo_d    = zero_q ? '1 : (q_neg_q ? negate(quo_q) : quo_q);
        hi_d    = r_neg_q ? negate(rem_q[Width-1:0]) : rem_q[Width-1:0];
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
